pc_ctrl: RTL
============

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64, PC and address width.
REQ-002 Parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 is the clock; rst_i input 1 is the reset.
REQ-005 en_i  input  1  advance enable; 0 = stall, all state holds.
REQ-006 icode_i  input  4  instruction code of the retiring instruction.
REQ-007 cnd_i  input  1  branch condition for JXX.
REQ-008 valc_i / valm_i / valp_i  input  ADDR_W each  constant word / memory-read value / fall-through PC.
REQ-009 pc_o  output  ADDR_W  registered current PC.
REQ-010 halted_o  output  1  registered; set by HALT.
REQ-011 ras_top_o  output  ADDR_W  predicted return address: top entry when non-empty, else 0.
REQ-012 ras_valid_o  output  1  stack non-empty.
REQ-013 ras_mispredict_o  output  1  one-cycle registered pulse on a bad RET prediction.
REQ-014 ras_ovf_o / ras_unf_o  output  1 each  sticky overflow / underflow flags.

Function
REQ-015 Updates SHALL occur only on a rising clk_i edge with en_i=1 and halted_o=0 (an "active edge").
REQ-016 Next pc_o SHALL be: JXX -> cnd_i ? valc_i : valp_i; CALL -> valc_i; RET -> valm_i; any other icode, including HALT and undefined codes -> valp_i.
REQ-017 HALT SHALL set halted_o=1; afterwards pc_o, the stack and the flags freeze until reset.
REQ-018 CALL SHALL push valp_i; occupancy count saturates at RAS_DEPTH.
REQ-019 CALL at full SHALL overwrite the oldest entry (circular write pointer wraps modulo RAS_DEPTH) and set ras_ovf_o.
REQ-020 RET with non-empty stack SHALL pop: decrement count and pointer; ras_mispredict_o=1 next cycle if the popped entry differs from valm_i.
REQ-021 RET with empty stack SHALL leave count at 0, set ras_unf_o and pulse ras_mispredict_o.
REQ-022 pc_o SHALL always take valm_i on RET, whatever the prediction.
REQ-023 Only one icode retires per edge, so no simultaneous push and pop exists.
REQ-024 ras_mispredict_o SHALL clear on every edge that does not set it, including stalled edges.
REQ-025 ras_top_o and ras_valid_o SHALL be combinational from registered stack state; no input-to-output combinational path.
REQ-026 Pointer and count arithmetic SHALL use clog2(RAS_DEPTH)-bit wrap and a clog2(RAS_DEPTH)+1-bit count.

Reset
REQ-027 rst_i=1 SHALL immediately force pc_o=RESET_PC, halted_o=0, count=0, pointer=0, ras_mispredict_o=0, ras_ovf_o=0 and ras_unf_o=0, including mid-operation or while halted.
REQ-028 Stack storage SHALL NOT be reset; entries are unreadable while count=0.
REQ-029 The first active edge after rst_i falls SHALL behave normally.

Structure
REQ-030 The icode constants (JXX, CALL, RET, HALT) SHALL come from the shared define.v; no local redefinition.
REQ-031 The return-address stack SHALL be one sub-module, ras_stack, with push, pop, top, valid, ovf and unf ports; pc_ctrl holds the PC register, the next-PC mux and the halt logic.

Verification
REQ-032 Reset, then JXX cnd=1 valc=0x40 valp=0x0A -> pc_o=0x40; JXX cnd=0 valp=0x13 -> pc_o=0x13.
REQ-033 CALL valc=0x100 valp=0x20, then RET valm=0x20 -> pc_o=0x100 then 0x20; ras_top_o=0x20 between; no mispredict; ras_valid_o=0 after.
REQ-034 DEPTH=8: nine CALLs with valp=1..9 -> ras_ovf_o=1; eight RETs with matching valm 9..2 -> no mispredict; ninth RET -> ras_unf_o=1 plus mispredict pulse.
REQ-035 CALL valp=0x30, RET valm=0x44 -> pc_o=0x44; ras_mispredict_o high exactly one cycle.
REQ-036 HALT valp=0x55 -> pc_o=0x55, halted_o=1; following CALL/JXX ignored; en_i=0 cycles hold all state.
REQ-037 rst_i asserted asynchronously mid-cycle with count=3 and flags set -> outputs reset before the next clk_i edge; ras_valid_o=0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared instruction-code definitions for the PC control slice.
// Every file that decodes icodes imports these constants.
package pc_ctrl_pkg;

  typedef logic [3:0] icode_t;

  localparam icode_t ICODE_HALT = 4'h0;
  localparam icode_t ICODE_NOP  = 4'h1;
  localparam icode_t ICODE_JXX  = 4'h7;
  localparam icode_t ICODE_CALL = 4'h8;
  localparam icode_t ICODE_RET  = 4'h9;

endpackage

// File: rtl/pc_ctrl_ras_stack.sv
// Circular return-address stack with a saturating occupancy count.
// At full, a push overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              valid,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              ovf_reg;
  logic              unf_reg;
  logic [PTR_W-1:0]  top_idx;

  // Storage is deliberately not reset; a zero count hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else if (push) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
      if (count_reg == FULL) begin
        ovf_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end else if (pop) begin
      if (count_reg == '0) begin
        unf_reg <= 1'b1;
      end else begin
        count_reg <= count_reg - CNT_W'(1);
        ptr_reg   <= ptr_reg - PTR_W'(1);
      end
    end
  end

  assign top_idx = ptr_reg - PTR_W'(1);
  assign valid   = (count_reg != '0);
  assign top     = valid ? mem[top_idx] : '0;
  assign ovf     = ovf_reg;
  assign unf     = unf_reg;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter register, next-PC selection and halt latch, with a
// return-address stack predicting RET targets and flagging mispredictions.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              ADDR_W    = 64,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [3:0]        icode_i,
  input  logic              cnd_i,
  input  logic [ADDR_W-1:0] valc_i,
  input  logic [ADDR_W-1:0] valm_i,
  input  logic [ADDR_W-1:0] valp_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic [ADDR_W-1:0] ras_top_o,
  output logic              ras_valid_o,
  output logic              ras_mispredict_o,
  output logic              ras_ovf_o,
  output logic              ras_unf_o
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              halted_reg;
  logic              halted_next;
  logic              mispredict_reg;
  logic              mispredict_next;
  logic              active;
  logic              push;
  logic              pop;

  assign active = en_i && !halted_reg;
  assign push   = active && (icode_i == ICODE_CALL);
  assign pop    = active && (icode_i == ICODE_RET);

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .pop       (pop),
    .push_data (valp_i),
    .top       (ras_top_o),
    .valid     (ras_valid_o),
    .ovf       (ras_ovf_o),
    .unf       (ras_unf_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_reg         <= RESET_PC;
      halted_reg     <= 1'b0;
      mispredict_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      halted_reg     <= halted_next;
      mispredict_reg <= mispredict_next;
    end
  end

  always_comb begin
    pc_next         = pc_reg;
    halted_next     = halted_reg;
    mispredict_next = 1'b0;
    if (active) begin
      pc_next = valp_i;
      case (icode_i)
        ICODE_JXX:  pc_next = cnd_i ? valc_i : valp_i;
        ICODE_CALL: pc_next = valc_i;
        ICODE_RET:  pc_next = valm_i;
        default:    pc_next = valp_i;
      endcase
      if (icode_i == ICODE_HALT) begin
        halted_next = 1'b1;
      end
      // An empty stack has no prediction, which always counts as a miss.
      if (pop) begin
        mispredict_next = !ras_valid_o || (ras_top_o != valm_i);
      end
    end
  end

  always_comb begin
    pc_o             = pc_reg;
    halted_o         = halted_reg;
    ras_mispredict_o = mispredict_reg;
  end

endmodule
